// File: rtl/rv523_clk_pkg.sv
// ============================================================================
// Module   : rv523_clk_pkg
// Purpose  : Shared state encoding and default phase timings for the
//            two-phase clock generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rv523_clk_pkg;

    localparam int HIGH_CYC_DEF = 2;
    localparam int GAP_CYC_DEF  = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_G1   = 3'd2,
        ST_P2   = 3'd3,
        ST_G2   = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/two_phase_clkgen.sv
// ============================================================================
// Module   : two_phase_clkgen
// Purpose  : Non-overlapping PHI1/PHI2 generator with run/halt/single-step
//            control and a machine-cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module two_phase_clkgen
    import rv523_clk_pkg::*;
#(
    parameter int HIGH_CYC = HIGH_CYC_DEF,
    parameter int GAP_CYC  = GAP_CYC_DEF,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             step_i,
    output logic             phi1_o,
    output logic             nphi1_o,
    output logic             phi2_o,
    output logic             nphi2_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] cyc_cnt_o
);

    localparam int MAX_CYC = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
    localparam int TIMER_W = $clog2(MAX_CYC + 1);
    localparam logic [TIMER_W-1:0] HIGH_LAST = TIMER_W'(HIGH_CYC - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYC - 1);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 cyc_done;
    logic                 phi1_q, phi1_d;
    logic                 phi2_q, phi2_d;
    logic                 nphi1_q, nphi2_q;
    logic                 halted_q, halted_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Outputs are registered from next-state decode: they feed clock nets.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            phi1_q   <= 1'b0;
            phi2_q   <= 1'b0;
            nphi1_q  <= 1'b1;
            nphi2_q  <= 1'b1;
            halted_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            phi1_q   <= phi1_d;
            phi2_q   <= phi2_d;
            nphi1_q  <= ~phi1_d;
            nphi2_q  <= ~phi2_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TIMER_W'(1);
        cyc_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (run_i || step_i) begin
                    state_d = ST_P1;
                end
            end
            ST_P1: begin
                if (timer_q == HIGH_LAST) begin
                    state_d = ST_G1;
                    timer_d = '0;
                end
            end
            ST_G1: begin
                if (timer_q == GAP_LAST) begin
                    state_d = ST_P2;
                    timer_d = '0;
                end
            end
            ST_P2: begin
                if (timer_q == HIGH_LAST) begin
                    state_d = ST_G2;
                    timer_d = '0;
                end
            end
            ST_G2: begin
                if (timer_q == GAP_LAST) begin
                    cyc_done = 1'b1;
                    state_d  = run_i ? ST_P1 : ST_IDLE;
                    timer_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        phi1_d   = (state_d == ST_P1);
        phi2_d   = (state_d == ST_P2);
        halted_d = (state_d == ST_IDLE);
        cnt_d    = cyc_done ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    assign phi1_o    = phi1_q;
    assign nphi1_o   = nphi1_q;
    assign phi2_o    = phi2_q;
    assign nphi2_o   = nphi2_q;
    assign halted_o  = halted_q;
    assign cyc_cnt_o = cnt_q;

endmodule

`default_nettype wire
